pipe_stage_elastic: RTL
=======================

Name: pipe_stage_elastic

Overview:
Parametrised elastic pipeline-stage register for the 5-stage MIPS core. It is the successor to the fixed-width IF/ID latch: a generic payload, a valid/ready handshake in place of a bare stall, a 2-entry skid buffer, synchronous flush, exception-code merge and a stall-cycle counter. It is instantiated between any two stages (F/D, D/E, E/M, M/W), with payload typically {instr, pc8}.

Parameters:
DATA_W, 64, payload width (instr + pc8)
EXC_W, 5, exception-code width; code 0 means "no exception"
CNT_W, 32, stall-counter width

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
flush  in  1  synchronous kill of all held and incoming beats (exception/eret)
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat this cycle
in_data  in  DATA_W  upstream payload
in_exc  in  EXC_W  exception code carried from earlier stages
in_bd  in  1  beat is in a branch-delay slot
local_exc  in  EXC_W  exception detected by the upstream stage for this beat
out_valid  out  1  head beat valid
out_ready  in  1  downstream accepts (0 = hazard stall)
out_data  out  DATA_W  head payload
out_exc  out  EXC_W  head merged exception code
out_bd  out  1  head delay-slot flag
occupancy  out  2  beats held (0..2)
stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Storage: main entry (drives out_*) and skid entry; each entry has valid, data, exc and bd fields.
- All outputs are registered. in_ready = !skid_valid, with no combinational path from out_ready.
- Accept: in_valid & in_ready & !flush. Drain: out_valid & out_ready.
- Exception merge at accept: stored exc = (in_exc != 0) ? in_exc : local_exc. Earliest-stage exception wins. exc and bd travel with their beat.
- Per cycle, when neither reset nor flush is active:
  - main empty or draining, skid valid: main <- skid; skid <- accepted beat if any, else skid empties.
  - main empty or draining, skid empty: main <- accepted beat if any, else main empties.
  - main full, not draining, beat accepted: skid <- beat.
  - main full, not draining, no beat accepted: hold everything (this reproduces the old stall-hold behaviour).
- Beats leave strictly in acceptance order. No beat is lost or duplicated.
- When an entry is empty, its data/exc/bd fields are 0. Instruction 0 is a nop, so a bubble is a nop with no exception.
- occupancy = main_valid + skid_valid. It never exceeds 2 because in_ready=0 whenever skid is full.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Throughput is 1 beat/cycle under continuous out_ready.
- Flush: next cycle both entries are invalid and zeroed, occupancy=0, and a beat offered in the flush cycle is discarded. stall_cnt is kept. Flush has priority over accept and drain, and any drain in the flush cycle is still honoured downstream.
- Reset: same as flush, and additionally stall_cnt=0. Reset mid-operation discards all held beats.
- Reset values: out_valid=0, out_data=0, out_exc=0, out_bd=0, occupancy=0, in_ready=1, stall_cnt=0.
- stall_cnt increments by 1 per stall cycle and saturates at all-ones with no wrap. It also counts during the flush cycle when the stall condition holds.
- No X on outputs after the first reset edge. Payload is opaque; no width conversion.

Decomposition:
- Shared package pipe_pkg: EXC_NONE=0, exception-code constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12), and default widths DATA_W/EXC_W.
- One sub-module: pipe_slot, a single entry register with load/clear/hold holding valid, data, exc and bd. It is instantiated twice, for main and skid.
- The top level holds the steering logic and stall_cnt.

Test Plan:
- Reset, then stream 3 beats A=0x11,B=0x22,C=0x33 with out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, 1-cycle latency, occupancy≤1, stall_cnt=0.
- Stall: out_ready=0 for 4 cycles while offering A,B,C -> A in main, B in skid, in_ready=0 from the cycle after B is accepted, C held upstream, occupancy=2, stall_cnt=4; release -> A,B,C in order with no loss.
- Exception merge: in_exc=0/local_exc=4 -> out_exc=4; in_exc=12/local_exc=4 -> out_exc=12; in_bd=1 -> out_bd=1 on that beat only.
- Flush with occupancy=2 plus an offered beat -> next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1, stall_cnt unchanged, offered beat never appears.
- Reset asserted mid-stall with stall_cnt=7 -> all outputs at reset values, stall_cnt=0; the next accepted beat appears after 1 cycle.
- Saturation: CNT_W=3, out_ready=0 for 10 cycles with a beat held -> stall_cnt reaches 7 and stays at 7.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline-stage registers.
// Holds the default payload/exception widths and the exception codes that travel
// with each beat. Code 0 doubles as "no exception" and as the interrupt code; a
// stage reporting an interrupt does so outside the per-beat exception field.
package pipe_pkg;

  localparam int unsigned PIPE_DATA_W = 64;  // {instr, pc8}
  localparam int unsigned PIPE_EXC_W  = 5;

  localparam int unsigned EXC_NONE = 0;

  typedef enum logic [PIPE_EXC_W-1:0] {
    ExcInt  = 5'd0,
    ExcAdel = 5'd4,
    ExcAdes = 5'd5,
    ExcRi   = 5'd10,
    ExcOv   = 5'd12
  } exc_code_e;

endpackage

// File: rtl/pipe_slot.sv
// Single beat register used for both the main and skid entries of an elastic stage.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   clear          synchronous clear (flush), same effect as reset
//   load           capture load_* this cycle; otherwise hold
//   load_valid     validity of the captured beat; an invalid load zeroes the fields
//   load_data/exc/bd  beat fields
//   valid, data, exc, bd  registered entry contents (fields are 0 when empty)
module pipe_slot import pipe_pkg::*; #(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned EXC_W  = PIPE_EXC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic [EXC_W-1:0]  load_exc,
  input  logic              load_bd,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [EXC_W-1:0]  exc,
  output logic              bd
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [EXC_W-1:0]  exc_q;
  logic              bd_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      exc_q   <= '0;
      bd_q    <= 1'b0;
    end else if (load) begin
      // Empty entries read as a nop bubble with no exception.
      valid_q <= load_valid;
      data_q  <= load_valid ? load_data : '0;
      exc_q   <= load_valid ? load_exc  : '0;
      bd_q    <= load_valid ? load_bd   : 1'b0;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign exc   = exc_q;
  assign bd    = bd_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with a 2-entry skid buffer.
// Sits between two pipeline stages; a main entry drives the outputs and a skid
// entry absorbs the one beat that may arrive while downstream stalls, so in_ready
// is a pure register output with no path from out_ready.
// Ports:
//   clk, reset          clock, synchronous active-high reset (also clears stall_cnt)
//   flush               kill all held beats and the beat offered this cycle
//   in_valid/in_ready   upstream handshake; in_data/in_exc/in_bd/local_exc beat fields
//   out_valid/out_ready downstream handshake; out_data/out_exc/out_bd head beat
//   occupancy           beats held (0..2)
//   stall_cnt           saturating count of cycles with out_valid & !out_ready
module pipe_stage_elastic import pipe_pkg::*; #(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned EXC_W  = PIPE_EXC_W,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_bd,
  input  logic [EXC_W-1:0]  local_exc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [EXC_W-1:0]  main_exc, skid_exc;
  logic              main_bd, skid_bd;

  logic              accept, drain, main_free;
  logic [EXC_W-1:0]  beat_exc;

  logic              main_load, main_load_valid;
  logic [DATA_W-1:0] main_load_data;
  logic [EXC_W-1:0]  main_load_exc;
  logic              main_load_bd;
  logic              skid_load;

  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  always_comb begin
    accept    = in_valid && !skid_valid && !flush;
    drain     = main_valid && out_ready;
    main_free = !main_valid || drain;

    // Earliest-stage exception wins.
    beat_exc = (in_exc != EXC_W'(EXC_NONE)) ? in_exc : local_exc;

    // Main refills whenever it is free: from skid first to keep order, else from input.
    main_load       = main_free;
    main_load_valid = skid_valid || accept;
    main_load_data  = skid_valid ? skid_data : in_data;
    main_load_exc   = skid_valid ? skid_exc  : beat_exc;
    main_load_bd    = skid_valid ? skid_bd   : in_bd;

    // Skid takes the new beat when main is busy, or refills/empties as it hands off
    // to main. When both are empty, accept goes straight to main and skid stays empty.
    skid_load = main_free ? skid_valid : accept;
  end

  pipe_slot #(
    .DATA_W(DATA_W),
    .EXC_W (EXC_W)
  ) u_main (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .load      (main_load),
    .load_valid(main_load_valid),
    .load_data (main_load_data),
    .load_exc  (main_load_exc),
    .load_bd   (main_load_bd),
    .valid     (main_valid),
    .data      (main_data),
    .exc       (main_exc),
    .bd        (main_bd)
  );

  pipe_slot #(
    .DATA_W(DATA_W),
    .EXC_W (EXC_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .load      (skid_load),
    .load_valid(accept),
    .load_data (in_data),
    .load_exc  (beat_exc),
    .load_bd   (in_bd),
    .valid     (skid_valid),
    .data      (skid_data),
    .exc       (skid_exc),
    .bd        (skid_bd)
  );

  // Counts stall cycles even during flush; only reset clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_exc   = main_exc;
  assign out_bd    = main_bd;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
  assign stall_cnt = stall_cnt_q;

endmodule
